mux4_scan_sequencer: RTL and testbench

Drives the select lines of the 4:1 decoder-based mux and samples its output, one channel at a time. On `start`, it steps `{s1,s0}` through channels 0→3, holds each for `DWELL` cycles, and captures `z` at the end of each dwell. After channel 3 it presents all four captured bits as one word with a one-cycle valid pulse. The block wraps the mux: upstream it drives the selects, downstream it consumes `z`.

---
 rtl/mux_scan_pkg.sv | 12 +
 rtl/mux4_scan_sequencer_if.sv | 17 +
 rtl/dwell_counter.sv | 29 ++
 rtl/mux4_scan_sequencer.sv | 95 +++++++++
 tb/tb_mux4_scan_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared state encoding and channel constants for the mux scan sequencer
package mux_scan_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam int         NUM_CH  = 4;
  localparam logic [1:0] LAST_CH = 2'd3;

endpackage

// File: rtl/mux4_scan_sequencer_if.sv
// rtl/mux4_scan_sequencer_if.sv - start/stop request, mux select/return and captured-word bundle
interface mux4_scan_sequencer_if;
  import mux_scan_pkg::*;

  logic              start;
  logic              stop;
  logic              z;
  logic              s1;
  logic              s0;
  logic              busy;
  logic [NUM_CH-1:0] sample;
  logic              sample_valid;

  // master is the sequencer itself; slave is whatever requests scans and hosts the mux
  modport master (input start, stop, z, output s1, s0, busy, sample, sample_valid);
  modport slave  (output start, stop, z, input s1, s0, busy, sample, sample_valid);
endinterface

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - per-channel dwell counter; tick marks the last cycle of a dwell
module dwell_counter #(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= (r_count == LAST) ? '0 : r_count + CNT_W'(1);
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/mux4_scan_sequencer.sv
// rtl/mux4_scan_sequencer.sv - steps a 4:1 mux through its channels and captures z; MUX_SCAN_CONT_EN selects continuous mode
module mux4_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux4_scan_sequencer_if.master bus
);

  state_t            r_state;
  logic [1:0]        r_ch;
  logic [NUM_CH-2:0] r_buf;
  logic [NUM_CH-1:0] r_sample;
  logic              r_sample_valid;
  logic              r_stop_pend;

  logic w_tick;
  logic w_scan;
  logic w_cap;
  logic w_cont;

  assign w_scan = (r_state == ST_SCAN);
  assign w_cap  = w_scan && w_tick;

`ifdef MUX_SCAN_CONT_EN
  // a stop seen on the final capture edge still ends this scan
  assign w_cont = !(r_stop_pend || bus.stop);
`else
  assign w_cont = 1'b0;
`endif

  dwell_counter #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!w_scan),
    .en    (w_scan),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_ch           <= 2'd0;
      r_buf          <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_stop_pend    <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state     <= ST_SCAN;
            r_ch        <= 2'd0;
            r_stop_pend <= bus.stop;
          end
        end
        ST_SCAN: begin
          if (bus.stop) begin
            r_stop_pend <= 1'b1;
          end
          if (w_cap) begin
            if (r_ch == LAST_CH) begin
              r_sample       <= {bus.z, r_buf};
              r_sample_valid <= 1'b1;
              r_ch           <= 2'd0;
              if (!w_cont) begin
                r_state     <= ST_IDLE;
                r_stop_pend <= 1'b0;
              end
            end else begin
              r_buf[r_ch] <= bus.z;
              r_ch        <= r_ch + 2'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // the channel register is the select; it is forced to 0 whenever the block idles
  assign bus.s1           = r_ch[1];
  assign bus.s0           = r_ch[0];
  assign bus.busy         = w_scan;
  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_sample_valid;

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// tb/tb_mux4_scan_sequencer.sv - scoreboard bench for mux4_scan_sequencer at DWELL=2 and DWELL=1
module tb_mux4_scan_sequencer;

`ifdef MUX_SCAN_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  typedef struct {
    int         dut;
    logic [3:0] val;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0] start_v;
  logic [1:0] stop_v;
  logic [3:0] pat [2];
  logic [1:0] sel_o [2];
  logic [3:0] sample_o [2];
  logic [1:0] busy_o;
  logic [1:0] valid_o;

  int   total = 0;
  int   bad = 0;
  int   edge_n = 0;
  int   dw [2] = '{2, 1};
  bit   act [2];
  bit   stp [2];
  int   e0 [2];
  bit   exp_v [2];
  logic [3:0] exp_sample [2];
  int   valid_cnt [2];
  exp_t sbq [$];

  mux4_scan_sequencer_if bus_a ();
  mux4_scan_sequencer_if bus_b ();

  mux4_scan_sequencer #(.DWELL(2), .CNT_W(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.master));
  mux4_scan_sequencer #(.DWELL(1), .CNT_W(8)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.master));

  assign bus_a.start = start_v[0];
  assign bus_b.start = start_v[1];
  assign bus_a.stop  = stop_v[0];
  assign bus_b.stop  = stop_v[1];
  assign sel_o[0]    = {bus_a.s1, bus_a.s0};
  assign sel_o[1]    = {bus_b.s1, bus_b.s0};
  assign bus_a.z     = pat[0][sel_o[0]];
  assign bus_b.z     = pat[1][sel_o[1]];
  assign sample_o[0] = bus_a.sample;
  assign sample_o[1] = bus_b.sample;
  assign busy_o      = {bus_b.busy, bus_a.busy};
  assign valid_o     = {bus_b.sample_valid, bus_a.sample_valid};

  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h want=%0h edge=%0d", name, k, got, want, edge_n);
    end
  endtask

  // Reference: a scan started at edge E ends at E+4*DWELL and returns the mux pattern
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        act[k] = 1'b0;
        stp[k] = 1'b0;
        exp_v[k] = 1'b0;
        exp_sample[k] = 4'd0;
      end
      sbq.delete();
    end else begin
      edge_n++;
      for (int k = 0; k < 2; k++) begin
        exp_v[k] = 1'b0;
        if (act[k]) begin
          if (stop_v[k]) stp[k] = 1'b1;
          if (edge_n == e0[k] + 4 * dw[k]) begin
            exp_v[k] = 1'b1;
            exp_sample[k] = pat[k];
            if (CONT && !stp[k]) begin
              e0[k] = edge_n;
              sbq.push_back('{k, pat[k], edge_n + 4 * dw[k]});
            end else begin
              act[k] = 1'b0;
              stp[k] = 1'b0;
            end
          end
        end else if (start_v[k]) begin
          act[k] = 1'b1;
          e0[k] = edge_n;
          stp[k] = stop_v[k];
          sbq.push_back('{k, pat[k], edge_n + 4 * dw[k]});
        end
      end
    end
  end

  always @(negedge clk) begin : mon
    int idx;
    int want_sel;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        want_sel = act[k] ? ((edge_n - e0[k]) / dw[k]) % 4 : 0;
        chk("busy", k, int'(busy_o[k]), int'(act[k]));
        chk("sel", k, int'(sel_o[k]), want_sel);
        chk("valid", k, int'(valid_o[k]), int'(exp_v[k]));
        chk("sample_reg", k, int'(sample_o[k]), int'(exp_sample[k]));
        if (valid_o[k]) begin
          valid_cnt[k]++;
          idx = -1;
          foreach (sbq[i]) if (idx < 0 && sbq[i].dut == k) idx = i;
          if (idx < 0) begin
            chk("unexpected_valid", k, 1, 0);
          end else begin
            chk("sb_sample", k, int'(sample_o[k]), int'(sbq[idx].val));
            chk("sb_time", k, edge_n, sbq[idx].at);
            sbq.delete(idx);
          end
        end
      end
    end
  end

  task automatic pulse(input bit a, input bit b, input bit with_stop);
    @(negedge clk);
    start_v = {b, a};
    stop_v = with_stop ? {b, a} : 2'b00;
    @(negedge clk);
    start_v = 2'b00;
    stop_v = 2'b00;
  endtask

  initial begin
    int v0;
    start_v = 2'b00;
    stop_v = 2'b00;
    pat[0] = 4'b0000;
    pat[1] = 4'b0000;
    valid_cnt[0] = 0;
    valid_cnt[1] = 0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    repeat (5) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("idle_sel", k, int'(sel_o[k]), 0);
      chk("idle_busy", k, int'(busy_o[k]), 0);
      chk("idle_sample", k, int'(sample_o[k]), 0);
      chk("idle_nvalid", k, valid_cnt[k], 0);
    end

    // i0..i3 = 1,0,1,1 on the DWELL=2 unit; 0,1,1,0 on the DWELL=1 unit
    pat[0] = 4'b1101;
    pat[1] = 4'b0110;
    pulse(1'b1, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    chk("dir_sample_d2", 0, int'(sample_o[0]), 4'hd);
    chk("dir_sample_d1", 1, int'(sample_o[1]), 4'h6);
    chk("dir_count_d2", 0, valid_cnt[0], 1);
    chk("dir_count_d1", 1, valid_cnt[1], 1);

    // start again three cycles into a scan
    v0 = valid_cnt[0];
    pat[0] = 4'b1010;
    pulse(1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk("restart_ignored_cnt", 0, valid_cnt[0] - v0, 1);
    chk("restart_sample", 0, int'(sample_o[0]), 4'ha);

    // reset while the DWELL=2 unit sits on channel 2
    v0 = valid_cnt[0];
    pat[0] = 4'b0111;
    pulse(1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("pre_reset_sel", 0, int'(sel_o[0]), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 0, int'(busy_o[0]), 0);
    chk("rst_sel", 0, int'(sel_o[0]), 0);
    chk("rst_sample", 0, int'(sample_o[0]), 0);
    chk("rst_valid", 0, int'(valid_o[0]), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_no_valid", 0, valid_cnt[0] - v0, 0);
    pulse(1'b1, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    chk("post_reset_sample", 0, int'(sample_o[0]), 4'h7);

    // continuous-mode stop: start at E0, stop sampled at E0+10
    v0 = valid_cnt[0];
    pat[0] = 4'b1001;
    pulse(1'b1, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    stop_v[0] = 1'b1;
    @(negedge clk);
    stop_v[0] = 1'b0;
    for (int i = 0; i < 40 && busy_o[0]; i++) @(negedge clk);
    chk("cont_idle", 0, int'(busy_o[0]), 0);
    chk("cont_pulses", 0, valid_cnt[0] - v0, CONT ? 2 : 1);

    // randomized phase
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!act[k] && $urandom_range(0, 7) == 0) begin
          pat[k] = 4'($urandom_range(0, 15));
          start_v[k] = 1'b1;
        end else begin
          start_v[k] = ($urandom_range(0, 15) == 0);
        end
        stop_v[k] = ($urandom_range(0, 19) == 0);
      end
    end

    @(negedge clk);
    start_v = 2'b00;
    stop_v = 2'b11;
    for (int i = 0; i < 100 && busy_o != 2'b00; i++) @(negedge clk);
    stop_v = 2'b00;
    chk("drain_idle", 0, int'(busy_o), 0);
    repeat (3) @(negedge clk);
    chk("sb_empty", 0, sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
